// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: registered, handshaked N-way select decoder.
// Captures an index command and drives a one-hot select vector, either held
// statically or auto-scanned up/down with wrap-around at N.
// Optional thermometer hold (mode 11) is built when DECODER_SCAN_THERMO_EN
// is defined; otherwise mode 11 behaves as a one-hot direct hold.
module decoder_scan_ctrl #(
    parameter  int N        = 64,
    parameter  int SCAN_DIV = 4,
    localparam int AW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] a,
    input  logic          scan_stop,
    output logic [N-1:0]  y,
    output logic          y_valid,
    output logic [AW-1:0] idx,
    output logic          wrap,
    output logic          err
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [AW:0]   N_LIM    = (AW + 1)'(N);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          down, down_n;
    logic [AW-1:0] idx_n;
    logic [N-1:0]  y_n;
    logic          y_valid_n;
    logic          wrap_q, wrap_n;
    logic          err_q, err_n;

    logic          accept;
    logic          in_range;
    logic          is_scan;
    logic [AW-1:0] step_idx;
    logic          step_wraps;
    logic [N-1:0]  cmd_y;

    function automatic logic [N-1:0] onehot(input logic [AW-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

`ifdef DECODER_SCAN_THERMO_EN
    // Bits 0..i set: shift an all-ones word right by (N-1-i).
    function automatic logic [N-1:0] thermo(input logic [AW-1:0] i);
        return {N{1'b1}} >> (IDX_LAST - i);
    endfunction
`endif

    assign in_ready = rst_n & enable & (state != SCAN);
    assign accept   = in_valid & in_ready;
    assign in_range = ({1'b0, a} < N_LIM);
    assign is_scan  = (mode == 2'b01) || (mode == 2'b10);
    assign wrap     = wrap_q & enable;
    assign err      = err_q & enable;

    // Select pattern for an accepted in-range command.
    always_comb begin
        cmd_y = onehot(a);
`ifdef DECODER_SCAN_THERMO_EN
        if (mode == 2'b11) begin
            cmd_y = thermo(a);
        end
`endif
    end

    // Next scan index with wrap at N (not 2^AW).
    always_comb begin
        step_idx   = idx;
        step_wraps = 1'b0;
        if (down) begin
            if (idx == '0) begin
                step_idx   = IDX_LAST;
                step_wraps = 1'b1;
            end else begin
                step_idx = idx - AW'(1);
            end
        end else begin
            if (idx == IDX_LAST) begin
                step_idx   = '0;
                step_wraps = 1'b1;
            end else begin
                step_idx = idx + AW'(1);
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        down_n    = down;
        idx_n     = idx;
        y_n       = y;
        y_valid_n = y_valid;
        wrap_n    = 1'b0;
        err_n     = 1'b0;
        if (!enable) begin
            state_n   = IDLE;
            cnt_n     = '0;
            y_n       = '0;
            y_valid_n = 1'b0;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (!in_range) begin
                            state_n   = IDLE;
                            y_n       = '0;
                            y_valid_n = 1'b0;
                            err_n     = 1'b1;
                        end else begin
                            state_n   = is_scan ? SCAN : HOLD;
                            down_n    = (mode == 2'b10);
                            cnt_n     = '0;
                            idx_n     = a;
                            y_n       = cmd_y;
                            y_valid_n = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (scan_stop) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt_n  = '0;
                        idx_n  = step_idx;
                        y_n    = onehot(step_idx);
                        wrap_n = step_wraps;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n   = IDLE;
                    y_n       = '0;
                    y_valid_n = 1'b0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: select vector, index, step counter, pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            down    <= 1'b0;
            idx     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            down    <= down_n;
            idx     <= idx_n;
            y       <= y_n;
            y_valid <= y_valid_n;
            wrap_q  <= wrap_n;
            err_q   <= err_n;
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: directed, table-driven bench for decoder_scan_ctrl.
// Instances: N=64/SCAN_DIV=4 (main table), N=10/SCAN_DIV=1 (range, fast
// scan), N=8/SCAN_DIV=2 (thermometer hold, enable drop).
module tb_decoder_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic        scan_stop;

    logic        iv64, rdy64, yv64, wr64, er64;
    logic [5:0]  a64, idx64;
    logic [63:0] y64;

    logic        iv10, rdy10, yv10, wr10, er10;
    logic [3:0]  a10, idx10;
    logic [9:0]  y10;

    logic        iv8, rdy8, yv8, wr8, er8;
    logic [2:0]  a8, idx8;
    logic [7:0]  y8;

    int total = 0;
    int bad   = 0;

    decoder_scan_ctrl #(.N(64), .SCAN_DIV(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(iv64), .in_ready(rdy64),
        .mode(mode), .a(a64), .scan_stop(scan_stop), .y(y64), .y_valid(yv64),
        .idx(idx64), .wrap(wr64), .err(er64)
    );

    decoder_scan_ctrl #(.N(10), .SCAN_DIV(1)) dut10 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(iv10), .in_ready(rdy10),
        .mode(mode), .a(a10), .scan_stop(scan_stop), .y(y10), .y_valid(yv10),
        .idx(idx10), .wrap(wr10), .err(er10)
    );

    decoder_scan_ctrl #(.N(8), .SCAN_DIV(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(iv8), .in_ready(rdy8),
        .mode(mode), .a(a8), .scan_stop(scan_stop), .y(y8), .y_valid(yv8),
        .idx(idx8), .wrap(wr8), .err(er8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        iv;
        logic [1:0]  mode;
        logic [5:0]  a;
        logic        stop;
        logic [63:0] y;
        logic        yv;
        logic [5:0]  idx;
        logic        wr;
        logic        er;
        logic        rdy;
    } vec_t;

    vec_t vq[$];

    function automatic logic [63:0] oh(input int n);
        logic [63:0] v;
        v = 64'd1;
        return v << n;
    endfunction

    function automatic void add(input logic en, input logic iv, input logic [1:0] md,
                                input logic [5:0] av, input logic st, input logic [63:0] ey,
                                input logic eyv, input logic [5:0] eidx, input logic ewr,
                                input logic eer, input logic erdy);
        vec_t v;
        v.en = en; v.iv = iv; v.mode = md; v.a = av; v.stop = st;
        v.y = ey; v.yv = eyv; v.idx = eidx; v.wr = ewr; v.er = eer; v.rdy = erdy;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] t3;
        logic [63:0] t63;
        logic [7:0]  t8_3;
        int          e10;
        logic [3:0]  hold10;

`ifdef DECODER_SCAN_THERMO_EN
        t3   = 64'h0000_0000_0000_000F;
        t63  = '1;
        t8_3 = 8'b0000_1111;
`else
        t3   = oh(3);
        t63  = oh(63);
        t8_3 = 8'b0000_1000;
`endif

        // Stimulus table for the N=64, SCAN_DIV=4 instance.
        add(1, 1, 2'b00, 37, 0, oh(37), 1, 37, 0, 0, 1);
        add(1, 0, 2'b00,  0, 0, oh(37), 1, 37, 0, 0, 1);
        add(1, 1, 2'b00,  0, 0, oh(0),  1,  0, 0, 0, 1);
        add(1, 1, 2'b01, 62, 0, oh(62), 1, 62, 0, 0, 0);
        add(1, 1, 2'b00,  3, 0, oh(62), 1, 62, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(1, 0, 2'b00, 0, 0, oh(62), 1, 62, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 2'b00, 0, 0, oh(63), 1, 63, 0, 0, 0);
        add(1, 0, 2'b00,  0, 0, oh(0),  1,  0, 1, 0, 0);
        add(1, 0, 2'b00,  0, 0, oh(0),  1,  0, 0, 0, 0);
        add(1, 0, 2'b00,  0, 1, oh(0),  1,  0, 0, 0, 1);
        add(1, 1, 2'b10,  1, 0, oh(1),  1,  1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 2'b00, 0, 0, oh(1), 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 2'b00, 0, 0, oh(0), 1, 0, 0, 0, 0);
        add(1, 0, 2'b00,  0, 0, oh(63), 1, 63, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 2'b00, 0, 0, oh(63), 1, 63, 0, 0, 0);
        add(1, 0, 2'b00,  0, 1, oh(63), 1, 63, 0, 0, 1);
        add(1, 0, 2'b00,  0, 0, oh(63), 1, 63, 0, 0, 1);
        add(1, 1, 2'b00,  5, 0, oh(5),  1,  5, 0, 0, 1);
        add(0, 1, 2'b00,  9, 0, 64'd0,  0,  5, 0, 0, 0);
        add(1, 0, 2'b00,  0, 0, 64'd0,  0,  5, 0, 0, 1);
        add(1, 1, 2'b11,  3, 0, t3,     1,  3, 0, 0, 1);
        add(1, 1, 2'b11, 63, 0, t63,    1, 63, 0, 0, 1);

        rst_n = 1'b0; enable = 1'b1; mode = 2'b00; scan_stop = 1'b0;
        iv64 = 0; a64 = '0; iv10 = 0; a10 = '0; iv8 = 0; a8 = '0;

        #12;
        chk("reset_y",     y64,   64'd0);
        chk("reset_yv",    yv64,  1'b0);
        chk("reset_idx",   idx64, 6'd0);
        chk("reset_wrap",  wr64,  1'b0);
        chk("reset_err",   er64,  1'b0);
        chk("reset_ready", rdy64, 1'b0);
        #1 rst_n = 1'b1;
        #1 chk("release_ready", rdy64, 1'b1);

        foreach (vq[i]) begin
            enable = vq[i].en; iv64 = vq[i].iv; mode = vq[i].mode;
            a64 = vq[i].a; scan_stop = vq[i].stop;
            @(posedge clk); #1;
            chk($sformatf("v%0d_y", i),     y64,   vq[i].y);
            chk($sformatf("v%0d_yv", i),    yv64,  vq[i].yv);
            chk($sformatf("v%0d_idx", i),   idx64, vq[i].idx);
            chk($sformatf("v%0d_wrap", i),  wr64,  vq[i].wr);
            chk($sformatf("v%0d_err", i),   er64,  vq[i].er);
            chk($sformatf("v%0d_ready", i), rdy64, vq[i].rdy);
        end
        iv64 = 0; scan_stop = 0; mode = 2'b00; enable = 1'b1;

        // Asynchronous reset in the middle of a scan.
        mode = 2'b01; a64 = 6'd5; iv64 = 1;
        @(posedge clk); #1;
        iv64 = 0; mode = 2'b00;
        chk("rst_scan_start", idx64, 6'd5);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_y",     y64,   64'd0);
        chk("rst_mid_yv",    yv64,  1'b0);
        chk("rst_mid_idx",   idx64, 6'd0);
        chk("rst_mid_ready", rdy64, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_rel_ready", rdy64, 1'b1);
        @(posedge clk); #1;
        chk("rst_rel_y",  y64,  64'd0);
        chk("rst_rel_yv", yv64, 1'b0);

        // N=10: out-of-range command, then scan up across the wrap at 10.
        a10 = 4'd12; iv10 = 1; mode = 2'b00;
        @(posedge clk); #1;
        iv10 = 0;
        chk("n10_oor_err", er10, 1'b1);
        chk("n10_oor_y",   y10,  10'd0);
        chk("n10_oor_yv",  yv10, 1'b0);
        chk("n10_oor_rdy", rdy10, 1'b1);
        @(posedge clk); #1;
        chk("n10_err_pulse", er10, 1'b0);
        a10 = 4'd8; iv10 = 1; mode = 2'b01;
        @(posedge clk); #1;
        iv10 = 0; mode = 2'b00;
        chk("n10_start_idx", idx10, 4'd8);
        chk("n10_start_y",   y10,   10'b01_0000_0000);
        chk("n10_start_rdy", rdy10, 1'b0);
        e10 = 8;
        for (int c = 0; c < 25; c++) begin
            e10 = (e10 + 1) % 10;
            @(posedge clk); #1;
            chk($sformatf("n10_scan%0d_idx", c),  idx10, e10);
            chk($sformatf("n10_scan%0d_y", c),    y10,   oh(e10));
            chk($sformatf("n10_scan%0d_wrap", c), wr10,  (e10 == 0));
        end
        hold10 = idx10;
        scan_stop = 1;
        @(posedge clk); #1;
        scan_stop = 0;
        chk("n10_stop_idx", idx10, e10);
        chk("n10_stop_y",   y10,   oh(e10));
        chk("n10_stop_rdy", rdy10, 1'b1);
        a10 = 4'd15; iv10 = 1;
        @(posedge clk); #1;
        iv10 = 0;
        chk("n10_hold_oor_err", er10, 1'b1);
        chk("n10_hold_oor_y",   y10,  10'd0);
        chk("n10_hold_oor_yv",  yv10, 1'b0);
        chk("n10_hold_oor_idx", idx10, hold10);

        // N=8: mode 11 hold, then enable drop.
        a8 = 3'd3; iv8 = 1; mode = 2'b11;
        @(posedge clk); #1;
        iv8 = 0; mode = 2'b00;
        chk("n8_m11_y",   y8,   t8_3);
        chk("n8_m11_yv",  yv8,  1'b1);
        chk("n8_m11_idx", idx8, 3'd3);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("n8_en_off_y",   y8,   8'd0);
        chk("n8_en_off_yv",  yv8,  1'b0);
        chk("n8_en_off_rdy", rdy8, 1'b0);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("n8_en_on_rdy", rdy8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
